// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO and FIFO-to-consumer signal bundle.
// master drives bytes and pops; slave is the FIFO.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      RXDATA;
    logic            RXDONE;
    logic            RD_READY;
    logic            OVR_CLR;
    logic [7:0]      RD_DATA;
    logic            RD_VALID;
    logic [ADDR_W:0] COUNT;
    logic            FULL;
    logic            EMPTY;
    logic            OVERRUN;

    modport master (
        output RXDATA, RXDONE, RD_READY, OVR_CLR,
        input  RD_DATA, RD_VALID, COUNT, FULL, EMPTY, OVERRUN
    );

    modport slave (
        input  RXDATA, RXDONE, RD_READY, OVR_CLR,
        output RD_DATA, RD_VALID, COUNT, FULL, EMPTY, OVERRUN
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO behind the UART receiver with first-word
// fall-through pop, occupancy flags and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovr_q, ovr_d;
    logic              rxdone_q;

    logic push_req;
    logic pop;
    logic push;
    logic drop;

    // A full FIFO still accepts a byte when a pop frees a slot this cycle.
    assign push_req = bus.RXDONE & ~rxdone_q;
    assign pop      = ~empty_q & bus.RD_READY;
    assign push     = push_req & (~full_q | pop);
    assign drop     = push_req & full_q & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        // Set wins over a simultaneous clear.
        if (drop) begin
            ovr_d = 1'b1;
        end else if (bus.OVR_CLR) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovr_q    <= 1'b0;
            rxdone_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovr_q    <= ovr_d;
            rxdone_q <= bus.RXDONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && push) begin
            mem_q[wr_ptr_q] <= bus.RXDATA;
        end
    end

    assign bus.RD_DATA  = mem_q[rd_ptr_q];
    assign bus.RD_VALID = ~empty_q;
    assign bus.COUNT    = count_q;
    assign bus.FULL     = full_q;
    assign bus.EMPTY    = empty_q;
    assign bus.OVERRUN  = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard
// filled on push and drained on pop.
module tb_uart_rx_fifo;
    logic CLK = 1'b0;
    logic RESET;
    int   n_chk = 0;
    int   n_err = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo_if #(.ADDR_W(4)) bus ();

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit keep);
        bus.RXDATA = b;
        bus.RXDONE = 1'b1;
        tick();
        bus.RXDONE = 1'b0;
        tick();
        if (keep) exp_q.push_back(b);
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] e;
        check({tag, "_valid"}, 32'(bus.RD_VALID), 1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(bus.RD_DATA), 32'(e));
        end
        bus.RD_READY = 1'b1;
        tick();
        bus.RD_READY = 1'b0;
    endtask

    initial begin
        logic [7:0] e;
        RESET        = 1'b1;
        bus.RXDATA   = '0;
        bus.RXDONE   = 1'b0;
        bus.RD_READY = 1'b0;
        bus.OVR_CLR  = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        check("rst_count", 32'(bus.COUNT), 0);
        check("rst_empty", 32'(bus.EMPTY), 1);
        check("rst_valid", 32'(bus.RD_VALID), 0);
        check("rst_ovr", 32'(bus.OVERRUN), 0);
        check("rst_full", 32'(bus.FULL), 0);

        // single byte, RXDONE held three cycles
        bus.RXDATA = 8'hA5;
        bus.RXDONE = 1'b1;
        tick();
        check("one_valid", 32'(bus.RD_VALID), 1);
        check("one_cnt1", 32'(bus.COUNT), 1);
        tick();
        tick();
        bus.RXDONE = 1'b0;
        exp_q.push_back(8'hA5);
        check("one_cnt3", 32'(bus.COUNT), 1);
        tick();
        pop_one("one_pop");
        check("one_cnt0", 32'(bus.COUNT), 0);
        check("one_empty", 32'(bus.EMPTY), 1);

        // RD_READY while empty is ignored
        bus.RD_READY = 1'b1;
        tick();
        bus.RD_READY = 1'b0;
        check("empty_rd_cnt", 32'(bus.COUNT), 0);

        // fill and overrun
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
        check("fill_full", 32'(bus.FULL), 1);
        check("fill_cnt", 32'(bus.COUNT), 16);
        check("fill_ovr0", 32'(bus.OVERRUN), 0);
        push_byte(8'h10, 1'b0);
        check("ovr_set", 32'(bus.OVERRUN), 1);
        check("ovr_cnt", 32'(bus.COUNT), 16);
        bus.OVR_CLR = 1'b1;
        tick();
        bus.OVR_CLR = 1'b0;
        check("ovr_clr", 32'(bus.OVERRUN), 0);
        bus.OVR_CLR = 1'b1;
        bus.RXDATA  = 8'h11;
        bus.RXDONE  = 1'b1;
        tick();
        bus.OVR_CLR = 1'b0;
        bus.RXDONE  = 1'b0;
        check("ovr_set_wins", 32'(bus.OVERRUN), 1);
        bus.OVR_CLR = 1'b1;
        tick();
        bus.OVR_CLR = 1'b0;
        check("ovr_clr2", 32'(bus.OVERRUN), 0);

        // push and pop together at full
        e = exp_q.pop_front();
        check("sim_data", 32'(bus.RD_DATA), 32'(e));
        bus.RD_READY = 1'b1;
        bus.RXDATA   = 8'h55;
        bus.RXDONE   = 1'b1;
        tick();
        bus.RD_READY = 1'b0;
        bus.RXDONE   = 1'b0;
        exp_q.push_back(8'h55);
        check("sim_cnt", 32'(bus.COUNT), 16);
        check("sim_full", 32'(bus.FULL), 1);
        check("sim_ovr", 32'(bus.OVERRUN), 0);
        for (int i = 0; i < 16; i++) pop_one("drain");
        check("drain_cnt", 32'(bus.COUNT), 0);
        check("drain_empty", 32'(bus.EMPTY), 1);

        // wrap-around with continuous pop
        bus.RD_READY = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.RXDATA = 8'(i);
            bus.RXDONE = 1'b1;
            tick();
            exp_q.push_back(8'(i));
            check("wrap_cnt", 32'(bus.COUNT <= 5'd1), 1);
            check("wrap_valid", 32'(bus.RD_VALID), 1);
            e = exp_q.pop_front();
            check("wrap_data", 32'(bus.RD_DATA), 32'(e));
            bus.RXDONE = 1'b0;
            tick();
            check("wrap_cnt0", 32'(bus.COUNT), 0);
        end
        bus.RD_READY = 1'b0;

        // reset mid-stream, RXDONE held across release
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i), 1'b1);
        check("mid_cnt5", 32'(bus.COUNT), 5);
        RESET      = 1'b1;
        bus.RXDATA = 8'h77;
        bus.RXDONE = 1'b1;
        tick();
        RESET = 1'b0;
        exp_q.delete();
        check("mid_rst_cnt", 32'(bus.COUNT), 0);
        check("mid_rst_empty", 32'(bus.EMPTY), 1);
        tick();
        check("mid_hold1", 32'(bus.COUNT), 0);
        tick();
        check("mid_hold2", 32'(bus.COUNT), 0);
        bus.RXDONE = 1'b0;
        tick();
        check("mid_fall", 32'(bus.COUNT), 0);
        bus.RXDONE = 1'b1;
        tick();
        bus.RXDONE = 1'b0;
        exp_q.push_back(8'h77);
        check("mid_rise", 32'(bus.COUNT), 1);
        pop_one("mid_pop");
        check("mid_end", 32'(bus.COUNT), 0);
        check("sb_left", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
